// File: rtl/video_pkg.sv
// Shared types for the video frame packetizer: pixel width,
// packetizer state encoding and the FIFO entry layout {data, sop, eop}.
package video_pkg;

    localparam int PIX_W   = 24;
    localparam int ENTRY_W = PIX_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TERM   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sop;
        logic             eop;
    } fifo_entry_t;

endpackage

// File: rtl/video_st_fifo.sv
// First-word-fall-through synchronous FIFO of packetizer entries.
// Ports: clk/rst_n, push/din/full on write side, pop/dout/empty on read side.
module video_st_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    output logic               full,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               wr_en;
    logic               rd_en;

    // full is judged on the pre-pop occupancy
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // head is gated so an empty FIFO presents all-zero payload
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_frame_packetizer.sv
// Packs a non-stallable pixel stream into Avalon-ST frames (sop/eop) via a FIFO.
// Ports: clk_clk/reset_reset_n, vsync/pix_*, src_* stream, status flags, frame_count.
module video_frame_packetizer
    import video_pkg::*;
#(
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              vsync,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [PIX_W-1:0]  src_data,
    output logic              src_startofpacket,
    output logic              src_endofpacket,
    output logic              src_valid,
    input  logic              src_ready,
    input  logic              status_clear,
    output logic              overflow,
    output logic              short_frame,
    output logic [15:0]       frame_count
);

    localparam int NPIX  = FRAME_W * FRAME_H;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPIX - 1);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               vsync_d;
    logic               vs_edge;
    logic               is_last;
    logic               is_eop;
    logic               push;
    fifo_entry_t        push_e;
    logic [ENTRY_W-1:0] pop_raw;
    fifo_entry_t        pop_e;
    logic               fifo_full;
    logic               fifo_empty;
    logic               set_ovf;
    logic               set_short;
    logic               frame_done;

    assign vs_edge = vsync && !vsync_d;
    assign is_last = (pix_cnt == LAST);
    assign is_eop  = pix_valid && is_last;

    always_comb begin
        state_n    = state;
        cnt_n      = pix_cnt;
        push       = 1'b0;
        push_e     = '0;
        set_ovf    = 1'b0;
        set_short  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (vs_edge) begin
                    state_n = ACTIVE;
                    cnt_n   = '0;
                end
            end
            ACTIVE: begin
                // an eop pixel on the edge cycle completes the frame
                if (vs_edge && pix_cnt != '0 && !is_eop) begin
                    set_short = 1'b1;
                    state_n   = TERM;
                end else if (pix_valid && fifo_full) begin
                    set_ovf = 1'b1;
                    state_n = TERM;
                end else if (pix_valid) begin
                    push        = 1'b1;
                    push_e.data = pix_data;
                    push_e.sop  = (pix_cnt == '0);
                    push_e.eop  = is_last;
                    if (is_last) begin
                        state_n    = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_n = pix_cnt + 1'b1;
                    end
                end
            end
            TERM: begin
                // close the broken packet with a zero filler eop beat
                if (!fifo_full) begin
                    push       = 1'b1;
                    push_e.eop = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            vsync_d     <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            pix_cnt     <= cnt_n;
            vsync_d     <= vsync;
            overflow    <= set_ovf | (overflow & ~status_clear);
            short_frame <= set_short | (short_frame & ~status_clear);
            if (frame_done)
                frame_count <= frame_count + 16'd1;
        end
    end

    video_st_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (push),
        .din   (push_e),
        .full  (fifo_full),
        .pop   (src_ready),
        .dout  (pop_raw),
        .empty (fifo_empty)
    );

    assign pop_e             = fifo_entry_t'(pop_raw);
    assign src_valid         = !fifo_empty;
    assign src_data          = pop_e.data;
    assign src_startofpacket = pop_e.sop;
    assign src_endofpacket   = pop_e.eop;

endmodule

// File: doc/video_frame_packetizer.md
VIDEO_FRAME_PACKETIZER -- requirements
Module: video_frame_packetizer

Interface
REQ-001 Parameter FRAME_W, default 640, active pixels per line.
REQ-002 Parameter FRAME_H, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=4).
REQ-004 clk_clk  in  1  pixel clock; all logic in this single domain.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 vsync  in  1  frame sync, active-high; rising edge = frame start.
REQ-007 pix_valid  in  1  pixel qualifier; source cannot be stalled.
REQ-008 pix_data  in  24  RGB888 pixel.
REQ-009 src_data  out  24  Avalon-ST data to the video DMA sink.
REQ-010 src_startofpacket  out  1  first beat of frame.
REQ-011 src_endofpacket  out  1  last beat of frame.
REQ-012 src_valid  out  1  beat available.
REQ-013 src_ready  in  1  sink accepts beat.
REQ-014 status_clear  in  1  synchronous one-cycle pulse that clears the sticky flags.
REQ-015 overflow  out  1  sticky: pixel lost because FIFO full.
REQ-016 short_frame  out  1  sticky: vsync edge before FRAME_W*FRAME_H pixels.
REQ-017 frame_count  out  16  completed, well-formed frames; wraps 0xFFFF->0.

Function
REQ-018 States IDLE, ACTIVE, TERM; the module SHALL enter IDLE on reset.
REQ-019 Vsync rising edge = vsync high while registered vsync_d low (1-cycle detect).
REQ-020 IDLE: on vsync edge -> ACTIVE with pixel counter=0; pixels seen in IDLE are discarded.
REQ-021 ACTIVE: each pix_valid pushes {pix_data, sop, eop} into FIFO; sop=1 iff counter==0, eop=1 iff counter==FRAME_W*FRAME_H-1.
REQ-022 Counter width = clog2(FRAME_W*FRAME_H); it increments per accepted pixel; after the eop push -> IDLE, frame_count+1.
REQ-023 ACTIVE: pix_valid with FIFO full -> pixel dropped, overflow=1, -> TERM.
REQ-024 ACTIVE: vsync edge with counter!=0 -> short_frame=1, -> TERM; same-cycle pix_valid is dropped.
REQ-025 ACTIVE: vsync edge with counter==0 -> remain ACTIVE (restart), no flag.
REQ-026 TERM: push one filler beat {24'h0, sop=0, eop=1} on the first cycle the FIFO is not full, then -> IDLE; all pixels are dropped in TERM; frame_count is not incremented.
REQ-027 Frame with eop on the same cycle as a vsync edge -> eop push wins, frame counted, -> IDLE; that edge is not used to start a frame.
REQ-028 FIFO: first-word-fall-through; src_valid = !empty; a pop occurs when src_valid && src_ready.
REQ-029 Push and pop in the same cycle when full: the push is refused (full is evaluated before the pop).
REQ-030 Latency: a pixel pushed at cycle N is presented on src_* at cycle N+1 when the FIFO is empty.
REQ-031 src_* outputs SHALL stay stable while src_valid && !src_ready.
REQ-032 status_clear clears overflow/short_frame; a simultaneous set event wins.

Reset
REQ-033 Asserting reset_reset_n low SHALL asynchronously force: state IDLE, counter 0, FIFO empty, src_valid 0, src_startofpacket/src_endofpacket 0, src_data 0, overflow 0, short_frame 0, frame_count 0, vsync_d 0.
REQ-034 Reset mid-frame discards FIFO contents; no terminating eop is emitted.
REQ-035 Deassertion is synchronised externally; the first vsync edge after release is detected normally.

Structure
REQ-036 Package video_pkg holds PIX_W=24, the state enum (IDLE/ACTIVE/TERM) and the FIFO entry typedef {data, sop, eop}.
REQ-037 The single sub-module video_st_fifo is a parameterised FWFT synchronous FIFO of 26-bit entries with full/empty outputs.

Verification (FRAME_W=4, FRAME_H=2, FIFO_DEPTH=4)
REQ-038 Vsync pulse, then 8 pixels 0x000001..0x000008, src_ready=1 -> 8 beats; sop on 0x000001, eop on 0x000008, frame_count=1, no flags.
REQ-039 Same frame with src_ready=0 throughout -> 4 beats are stored; 5th pixel sets overflow=1; after src_ready=1, beats 1..4 then filler 0x000000 with eop; frame_count=0.
REQ-040 Vsync edge, 5 pixels, vsync edge -> short_frame=1, 5 beats then filler eop beat; the next 8 pixels are not output until another vsync edge.
REQ-041 src_ready toggles 1/0 every cycle during a full frame -> no beat lost or duplicated, data stable while stalled, frame_count=1.
REQ-042 reset_reset_n low after 3 pixels -> outputs are zero immediately; the next vsync plus 8 pixels gives a clean frame with sop/eop.
REQ-043 status_clear pulse on the same cycle as an overflow event -> overflow stays 1; the next status_clear alone clears it.
